// File: rtl/gate_bist_pkg.sv
// Shared types and truth-table constants for the 2-input gate BIST engine.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    FINISH
  } bist_state_e;

  typedef logic [1:0] vec_idx_t;

  // Expected output per input vector; bit index is {a,b}.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  localparam int TIMER_W = 8;

endpackage

// File: rtl/gate_bist_timer.sv
// Loadable 8-bit down-counter with a zero flag; times the settle dwell.
module gate_bist_timer
  import gate_bist_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_bist.sv
// BIST engine: drives all four {a,b} vectors into a 2-input gate, waits
// SETTLE_CYCLES, checks y against TRUTH_TABLE. Optional macro
// GATE_BIST_ERRCNT_EN adds an err_cnt output counting mismatches per run.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_NAND,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_idx
`ifdef GATE_BIST_ERRCNT_EN
  ,
  output logic [2:0] err_cnt
`endif
);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  bist_state_e state, state_next;
  vec_idx_t    idx;
  logic        fail_seen;
  logic        timer_load;
  logic        timer_en;
  logic        timer_zero;
  logic        mismatch;

  gate_bist_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      IDLE:   if (start) state_next = DRIVE;
      DRIVE: begin
        timer_load = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        if (timer_zero) state_next = CHECK;
        else            timer_en   = 1'b1;
      end
      CHECK:  state_next = (idx == 2'd3) ? FINISH : DRIVE;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mismatch = (y != TRUTH_TABLE[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_idx  <= '0;
      idx       <= '0;
      fail_seen <= 1'b0;
`ifdef GATE_BIST_ERRCNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            idx       <= '0;
            pass      <= 1'b0;
            fail_idx  <= '0;
            fail_seen <= 1'b0;
`ifdef GATE_BIST_ERRCNT_EN
            err_cnt   <= '0;
`endif
          end
        end
        DRIVE: {a, b} <= idx;
        CHECK: begin
          if (mismatch) begin
            if (!fail_seen) begin
              fail_idx  <= idx;
              fail_seen <= 1'b1;
            end
`ifdef GATE_BIST_ERRCNT_EN
            err_cnt <= err_cnt + 3'd1;
`endif
          end
          // The last vector leaves idx at 3; it never wraps.
          if (idx != 2'd3) idx <= idx + 2'd1;
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= ~fail_seen;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: a NAND-configured instance with a
// switchable faulty gate model, and an XOR instance with SETTLE_CYCLES=1.
module tb_gate_bist;
  import gate_bist_pkg::*;

  typedef enum int {G_NAND, G_STUCK1, G_AND} gate_mode_e;

  typedef struct {
    logic       pass;
    logic [1:0] fidx;
    logic [2:0] ec;
    int         len;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic a0, b0, y0, busy0, done0, pass0;
  logic a1, b1, y1, busy1, done1, pass1;
  logic [1:0] fidx0, fidx1;
  logic [2:0] ec0, ec1;
  gate_mode_e mode;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t q0[$];
  exp_t q1[$];

  int         run_start[2] = '{0, 0};
  int         last_done[2] = '{0, 0};
  logic [7:0] trace[2]     = '{8'h0, 8'h0};
  int         tcnt[2]      = '{0, 0};
  logic       busy_q[2]    = '{1'b0, 1'b0};
  logic [1:0] ab_q[2]      = '{2'b0, 2'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (mode)
      G_STUCK1: y0 = 1'b1;
      G_AND:    y0 = a0 & b0;
      default:  y0 = ~(a0 & b0);
    endcase
  end
  assign y1 = a1 ^ b1;

  gate_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_idx(fidx0)
`ifdef GATE_BIST_ERRCNT_EN
    , .err_cnt(ec0)
`endif
  );

  gate_bist #(.TRUTH_TABLE(TT_XOR), .SETTLE_CYCLES(1)) dut_x (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_idx(fidx1)
`ifdef GATE_BIST_ERRCNT_EN
    , .err_cnt(ec1)
`endif
  );

`ifndef GATE_BIST_ERRCNT_EN
  assign ec0 = 3'd0;
  assign ec1 = 3'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tracks each run's start cycle and {a,b} trace, and on done pops
  // the expected result from the channel's queue.
  task automatic mon_step(input int ch, input logic busy, input logic done,
                          input logic pass, input logic [1:0] ab,
                          input logic [1:0] fidx, input logic [2:0] ec);
    exp_t e;
    if (busy && !busy_q[ch]) begin
      run_start[ch] = cyc;
      trace[ch]     = 8'h0;
      tcnt[ch]      = 0;
    end else if (busy && (tcnt[ch] == 0 || ab != ab_q[ch])) begin
      trace[ch] = {trace[ch][5:0], ab};
      tcnt[ch]++;
      ab_q[ch]  = ab;
    end
    if (done) begin
      if ((ch == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done ch%0d: got done=1 required no pulse", ch);
      end else begin
        e = (ch == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("pass ch%0d", ch), 32'(pass), 32'(e.pass));
        check($sformatf("fail_idx ch%0d", ch), 32'(fidx), 32'(e.fidx));
`ifdef GATE_BIST_ERRCNT_EN
        check($sformatf("err_cnt ch%0d", ch), 32'(ec), 32'(e.ec));
`endif
        check($sformatf("run_len ch%0d", ch), 32'(cyc - run_start[ch]), 32'(e.len));
        check($sformatf("ab_trace ch%0d", ch), 32'(trace[ch]), 32'h1B);
        check($sformatf("ab_steps ch%0d", ch), 32'(tcnt[ch]), 32'd4);
        if (e.gap != 0)
          check($sformatf("done_gap ch%0d", ch), 32'(cyc - last_done[ch]), 32'(e.gap));
      end
      last_done[ch] = cyc;
    end
    busy_q[ch] = busy;
  endtask

  always @(negedge clk) begin
    mon_step(0, busy0, done0, pass0, {a0, b0}, fidx0, ec0);
    mon_step(1, busy1, done1, pass1, {a1, b1}, fidx1, ec1);
  end

  task automatic pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q0.size() != 0 || q1.size() != 0); i++)
      @(negedge clk);
    check("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ab"}, 32'({a0, b0}), 32'd0);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_pass"}, 32'(pass0), 32'd0);
    check({tag, "_fail_idx"}, 32'(fidx0), 32'd0);
`ifdef GATE_BIST_ERRCNT_EN
    check({tag, "_err_cnt"}, 32'(ec0), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = G_NAND;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Good NAND gate.
    q0.push_back('{1'b1, 2'd0, 3'd0, 17, 0});
    pulse_start0();
    check("busy_after_start", 32'(busy0), 32'd1);
    check("pass_cleared_at_start", 32'(pass0), 32'd0);
    drain(60);
    repeat (3) @(negedge clk);
    check("ab_hold_11", 32'({a0, b0}), 32'd3);
    check("pass_held", 32'(pass0), 32'd1);

    // y stuck-at-1: only vector 11 mismatches.
    mode = G_STUCK1;
    q0.push_back('{1'b0, 2'd3, 3'd1, 17, 0});
    pulse_start0();
    drain(60);

    // AND gate against the NAND table: all four vectors mismatch.
    mode = G_AND;
    q0.push_back('{1'b0, 2'd0, 3'd4, 17, 0});
    pulse_start0();
    drain(60);
    repeat (2) @(negedge clk);
    check("fail_pass_held", 32'(pass0), 32'd0);

    // Reset during SETTLE of vector 10; no done may follow.
    mode = G_NAND;
    pulse_start0();
    begin
      int i;
      for (i = 0; i < 40 && !(busy0 && a0 && !b0); i++) @(negedge clk);
      check("reach_vec10", 32'(busy0 && a0 && !b0), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    q0.push_back('{1'b1, 2'd0, 3'd0, 17, 0});
    pulse_start0();
    drain(60);

    // start held high: back-to-back runs, done every 18 cycles.
    q0.push_back('{1'b1, 2'd0, 3'd0, 17, 0});
    q0.push_back('{1'b1, 2'd0, 3'd0, 17, 18});
    @(negedge clk);
    start0 = 1'b1;
    for (int i = 0; i < 40 && !done0; i++) @(negedge clk);
    @(negedge clk);
    start0 = 1'b0;
    drain(60);

    // Second start pulse mid-run is ignored.
    q0.push_back('{1'b1, 2'd0, 3'd0, 17, 0});
    pulse_start0();
    repeat (5) @(negedge clk);
    pulse_start0();
    drain(60);
    repeat (25) @(negedge clk);

    // XOR instance with the minimum settle time.
    q1.push_back('{1'b1, 2'd0, 3'd0, 13, 0});
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    drain(60);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
